// File: rtl/spi_master_if.sv
// Command/data handshake between the local bus controller and spi_master.
// The controller drives the master modport; spi_master uses the slave modport.
interface spi_master_if;
  logic       cmd_vld;
  logic       cmd_rdy;
  logic       cmd_rd;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_len;
  logic [7:0] tx_dat;
  logic       tx_ack;
  logic [7:0] rx_dat;
  logic       rx_vld;
  logic       busy;

  modport master (
    output cmd_vld, cmd_rd, cmd_addr, cmd_len, tx_dat,
    input  cmd_rdy, tx_ack, rx_dat, rx_vld, busy
  );

  modport slave (
    input  cmd_vld, cmd_rd, cmd_addr, cmd_len, tx_dat,
    output cmd_rdy, tx_ack, rx_dat, rx_vld, busy
  );
endinterface

// File: rtl/spi_master.sv
// Oversampled SPI initiator (CPOL=1/CPHA=1): op byte, address byte, then
// cmd_len+1 data bytes per command, all outputs registered.
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_LEAD = 4,
  parameter int CS_GAP  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_master_if.slave bus,
  output logic        CSn,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);
  localparam logic [7:0] OP_WR   = 8'h3c;
  localparam logic [7:0] OP_RD   = 8'h5b;
  localparam logic [7:0] DIV_LD  = 8'(CLK_DIV - 1);
  localparam logic [7:0] LEAD_LD = 8'(CS_LEAD - 1);
  localparam logic [7:0] GAP_LD  = 8'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

  state_t     state_q;
  logic [7:0] div_q;
  logic [2:0] bit_q;
  logic [8:0] byte_q;
  logic [7:0] tx_sh_q;
  logic [7:0] rx_sh_q;
  logic [7:0] addr_q;
  logic [7:0] len_q;
  logic       rd_q;
  logic       csn_q;
  logic       sclk_q;
  logic       mosi_q;
  logic       rdy_q;
  logic       busy_q;
  logic       ack_q;
  logic       rxv_q;
  logic [7:0] rx_dat_q;
  logic       rx_pend_q;

  logic [7:0] op_d;
  logic [8:0] nbyte_d;
  logic       cur_data_d;
  logic       nxt_data_d;
  logic [7:0] nxt_dat_d;

  // byte_q counts remaining bytes after the current one: op = len+2, addr = len+1
  always_comb begin
    op_d       = rd_q ? OP_RD : OP_WR;
    nbyte_d    = byte_q - 9'd1;
    cur_data_d = (byte_q <= {1'b0, len_q});
    nxt_data_d = (nbyte_d <= {1'b0, len_q});
    if (!nxt_data_d)  nxt_dat_d = addr_q;
    else if (rd_q)    nxt_dat_d = 8'hff;
    else              nxt_dat_d = bus.tx_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= 8'd0;
      bit_q     <= 3'd0;
      byte_q    <= 9'd0;
      tx_sh_q   <= 8'hff;
      rx_sh_q   <= 8'h00;
      addr_q    <= 8'h00;
      len_q     <= 8'h00;
      rd_q      <= 1'b0;
      csn_q     <= 1'b1;
      sclk_q    <= 1'b1;
      mosi_q    <= 1'b1;
      rdy_q     <= 1'b1;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      rxv_q     <= 1'b0;
      rx_dat_q  <= 8'h00;
      rx_pend_q <= 1'b0;
    end else begin
      ack_q     <= 1'b0;
      rxv_q     <= 1'b0;
      rx_pend_q <= 1'b0;
      if (rx_pend_q) begin
        rx_dat_q <= rx_sh_q;
        rxv_q    <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (bus.cmd_vld && rdy_q) begin
            rd_q    <= bus.cmd_rd;
            addr_q  <= bus.cmd_addr;
            len_q   <= bus.cmd_len;
            byte_q  <= {1'b0, bus.cmd_len} + 9'd2;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            csn_q   <= 1'b0;
            div_q   <= LEAD_LD;
            state_q <= LEAD;
          end
        end
        LEAD: begin
          if (div_q == 8'd0) begin
            sclk_q  <= 1'b0;
            mosi_q  <= op_d[7];
            tx_sh_q <= {op_d[6:0], 1'b1};
            bit_q   <= 3'd0;
            div_q   <= DIV_LD;
            state_q <= SHIFT;
          end else begin
            div_q <= div_q - 8'd1;
          end
        end
        SHIFT: begin
          if (div_q != 8'd0) begin
            div_q <= div_q - 8'd1;
          end else if (!sclk_q) begin
            sclk_q  <= 1'b1;
            rx_sh_q <= {rx_sh_q[6:0], MISO};
            div_q   <= DIV_LD;
            if (bit_q == 3'd7 && cur_data_d && rd_q) rx_pend_q <= 1'b1;
          end else begin
            // end of a full bit period: next bit, next byte, or finish
            div_q <= DIV_LD;
            if (bit_q != 3'd7) begin
              sclk_q  <= 1'b0;
              mosi_q  <= tx_sh_q[7];
              tx_sh_q <= {tx_sh_q[6:0], 1'b1};
              bit_q   <= bit_q + 3'd1;
            end else if (byte_q == 9'd0) begin
              state_q <= TRAIL;
            end else begin
              sclk_q  <= 1'b0;
              byte_q  <= nbyte_d;
              bit_q   <= 3'd0;
              mosi_q  <= nxt_dat_d[7];
              tx_sh_q <= {nxt_dat_d[6:0], 1'b1};
              if (nxt_data_d && !rd_q) ack_q <= 1'b1;
            end
          end
        end
        TRAIL: begin
          if (div_q == 8'd0) begin
            csn_q   <= 1'b1;
            mosi_q  <= 1'b1;
            div_q   <= GAP_LD;
            state_q <= GAP;
          end else begin
            div_q <= div_q - 8'd1;
          end
        end
        GAP: begin
          if (div_q == 8'd0) begin
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            div_q <= div_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_rdy = rdy_q;
  assign bus.busy    = busy_q;
  assign bus.tx_ack  = ack_q;
  assign bus.rx_vld  = rxv_q;
  assign bus.rx_dat  = rx_dat_q;
  assign CSn         = csn_q;
  assign SCLK        = sclk_q;
  assign MOSI        = mosi_q;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: behavioural SPI slave plus scoreboard queues of
// expected MOSI bytes and read data.
`timescale 1ns/1ps
module tb_spi_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_if b();
  spi_master_if b2();
  logic CSn, SCLK, MOSI;
  logic MISO = 1'b1;
  logic CSn2, SCLK2, MOSI2;
  logic miso2 = 1'b1;

  spi_master #(.CLK_DIV(4), .CS_LEAD(4), .CS_GAP(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b.slave),
    .CSn(CSn), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );

  spi_master #(.CLK_DIV(255), .CS_LEAD(4), .CS_GAP(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave),
    .CSn(CSn2), .SCLK(SCLK2), .MOSI(MOSI2), .MISO(miso2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // scoreboards
  logic [7:0] exp_b[$];
  logic [7:0] exp_rx[$];
  int n_extra = 0;

  // tx data source advances on every tx_ack
  logic [7:0] tx_base = 8'h00;
  logic [7:0] tx_step = 8'h00;
  int n_ack = 0;
  int ack_base = 0;
  assign b.tx_dat = tx_base + tx_step * 8'(n_ack - ack_base);

  // monitor, sampled on the inactive edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic csn_p = 1'b1, sclk_p = 1'b1;
  int n_rx = 0, n_rise = 0, csn_low = 0, t_fall = 0, t_rise = 0;
  int n_acc = 0, rdy_cnt = 0;
  int ack_t[$];

  always @(negedge clk) begin
    if (b.tx_ack) begin
      n_ack++;
      ack_t.push_back(cyc);
    end
    if (b.rx_vld) begin
      n_rx++;
      if (exp_rx.size() > 0) chk("rx_dat", b.rx_dat, exp_rx.pop_front());
      else n_extra++;
    end
    if (!CSn && csn_p) begin
      t_fall  = cyc;
      n_rise  = 0;
      csn_low = 0;
    end
    if (CSn && !csn_p) t_rise = cyc;
    if (!CSn) csn_low++;
    if (SCLK && !sclk_p && !CSn) n_rise++;
    if (b.cmd_vld && b.cmd_rdy) n_acc++;
    if (b.cmd_rdy) rdy_cnt++;
    csn_p = CSn;
    sclk_p = SCLK;
  end

  // behavioural SPI slave
  logic [7:0] slv_sh = 8'h00, slv_op = 8'h00, slv_out = 8'h00;
  int slv_bit = 0, slv_byte = 0;

  always @(negedge CSn) begin
    slv_bit = 0;
    slv_byte = 0;
  end

  always @(posedge SCLK) begin
    if (!CSn) begin
      slv_sh = {slv_sh[6:0], MOSI};
      slv_bit++;
      if (slv_bit == 8) begin
        if (slv_byte == 0) slv_op = slv_sh;
        if (exp_b.size() > 0) chk("mosi_byte", slv_sh, exp_b.pop_front());
        else n_extra++;
        slv_byte++;
        slv_bit = 0;
      end
    end
  end

  always @(negedge SCLK) begin
    if (!CSn) begin
      if (slv_byte >= 2 && slv_op == 8'h5b) MISO = slv_out[7 - slv_bit];
      else MISO = ~MISO;
    end
  end

  task automatic issue(input logic rd, input logic [7:0] addr, input logic [7:0] len,
                       input logic [7:0] d0, input logic [7:0] step);
    int w = 0;
    while (!b.cmd_rdy && w < 5000) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 5000) chk("rdy_timeout", w, 0);
    exp_b.push_back(rd ? 8'h5b : 8'h3c);
    exp_b.push_back(addr);
    for (int i = 0; i <= int'(len); i++) begin
      if (rd) begin
        exp_b.push_back(8'hff);
        exp_rx.push_back(slv_out);
      end else begin
        exp_b.push_back(d0 + step * 8'(i));
      end
    end
    tx_base = d0;
    tx_step = step;
    ack_base = n_ack;
    b.cmd_rd = rd;
    b.cmd_addr = addr;
    b.cmd_len = len;
    b.cmd_vld = 1'b1;
    @(posedge clk); #1;
    b.cmd_vld = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int w = 0;
    while ((b.busy || !b.cmd_rdy) && w < budget) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= budget) chk("done_timeout", w, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, r0, acc0, rdy_a, rdy_b, sz, w, h;
    b.cmd_vld = 1'b0; b.cmd_rd = 1'b0; b.cmd_addr = 8'h00; b.cmd_len = 8'h00;
    b2.cmd_vld = 1'b0; b2.cmd_rd = 1'b0; b2.cmd_addr = 8'h00; b2.cmd_len = 8'h00;
    b2.tx_dat = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_csn", CSn, 1);
    chk("rst_sclk", SCLK, 1);
    chk("rst_mosi", MOSI, 1);
    chk("rst_rdy", b.cmd_rdy, 1);
    chk("rst_busy", b.busy, 0);
    chk("rst_ack", b.tx_ack, 0);
    chk("rst_rxvld", b.rx_vld, 0);
    chk("rst_rxdat", b.rx_dat, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single write
    a0 = n_ack;
    issue(1'b0, 8'h12, 8'h00, 8'ha5, 8'h00);
    wait_done(2000);
    chk("wr_ack", n_ack - a0, 1);
    chk("wr_rise", n_rise, 24);
    chk("wr_csn_low", csn_low, 200);
    chk("wr_latch", slv_op == 8'h3c, 1);

    // single read
    slv_out = 8'hc3;
    a0 = n_ack; r0 = n_rx;
    issue(1'b1, 8'h40, 8'h00, 8'h00, 8'h00);
    wait_done(2000);
    chk("rd_rxvld", n_rx - r0, 1);
    chk("rd_no_ack", n_ack - a0, 0);
    chk("rd_rise", n_rise, 24);

    // burst write
    a0 = n_ack;
    issue(1'b0, 8'h30, 8'h03, 8'h01, 8'h01);
    wait_done(4000);
    chk("burst_ack", n_ack - a0, 4);
    chk("burst_rise", n_rise, 48);
    sz = ack_t.size();
    for (int i = 1; i < 4; i++) chk("burst_ack_gap", ack_t[sz - 4 + i] - ack_t[sz - 5 + i], 64);

    // back-to-back with cmd_vld held high
    acc0 = n_acc;
    for (int k = 0; k < 2; k++) begin
      exp_b.push_back(8'h3c);
      exp_b.push_back(8'h21);
      exp_b.push_back(8'h5a);
    end
    tx_base = 8'h5a; tx_step = 8'h00; ack_base = n_ack;
    b.cmd_rd = 1'b0; b.cmd_addr = 8'h21; b.cmd_len = 8'h00; b.cmd_vld = 1'b1;
    w = 0;
    while (n_acc < acc0 + 1 && w < 100) begin @(posedge clk); #1; w++; end
    if (w >= 100) chk("b2b_acc1_timeout", w, 0);
    rdy_a = rdy_cnt;
    w = 0;
    while (n_acc < acc0 + 2 && w < 3000) begin @(posedge clk); #1; w++; end
    if (w >= 3000) chk("b2b_acc2_timeout", w, 0);
    rdy_b = rdy_cnt;
    @(negedge clk); #1;
    b.cmd_vld = 1'b0;
    chk("b2b_gap_ge", (t_fall - t_rise) >= 8, 1);
    chk("b2b_rdy_cycles", rdy_b - rdy_a, 1);
    wait_done(2000);

    // reset in the middle of a read's address byte
    slv_out = 8'h3e;
    issue(1'b1, 8'h40, 8'h00, 8'h00, 8'h00);
    r0 = n_rx;
    repeat (4 + 64 + 24) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_csn", CSn, 1);
    chk("arst_sclk", SCLK, 1);
    chk("arst_mosi", MOSI, 1);
    chk("arst_rdy", b.cmd_rdy, 1);
    chk("arst_busy", b.busy, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_b.delete();
    exp_rx.delete();
    repeat (4) @(posedge clk);
    #1;
    chk("arst_no_rx", n_rx - r0, 0);
    a0 = n_ack;
    issue(1'b0, 8'h77, 8'h01, 8'h9e, 8'h11);
    wait_done(3000);
    chk("post_rst_ack", n_ack - a0, 2);
    chk("post_rst_rise", n_rise, 32);

    // 256-byte write
    a0 = n_ack;
    issue(1'b0, 8'h00, 8'hff, 8'h00, 8'h01);
    wait_done(20000);
    chk("len256_ack", n_ack - a0, 256);
    chk("len256_rise", n_rise, 2064);
    chk("len256_rdy", b.cmd_rdy, 1);
    chk("len256_busy", b.busy, 0);

    // CLK_DIV=255 half-period
    b2.cmd_rd = 1'b0; b2.cmd_addr = 8'h01; b2.cmd_len = 8'h00; b2.cmd_vld = 1'b1;
    @(posedge clk); #1;
    b2.cmd_vld = 1'b0;
    w = 0;
    while (SCLK2 && w < 100) begin @(posedge clk); #1; w++; end
    if (w >= 100) chk("div255_start_timeout", w, 0);
    h = 0;
    while (!SCLK2 && h < 1000) begin @(posedge clk); #1; h++; end
    chk("div255_low", h, 255);
    h = 0;
    while (SCLK2 && h < 1000) begin @(posedge clk); #1; h++; end
    chk("div255_high", h, 255);

    chk("exp_b_empty", exp_b.size(), 0);
    chk("exp_rx_empty", exp_rx.size(), 0);
    chk("extra_outputs", n_extra, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
